// File: rtl/sfifo_flags_if.sv
// Handshake bundle between a producer/consumer and sfifo_flags.
// master drives requests and write data; slave (the FIFO) drives data and status.
interface sfifo_flags_if #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
);
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              i_rd;
    logic              i_clr_err;
    logic [BW-1:0]     o_data;
    logic              o_empty;
    logic              o_full;
    logic [LGFLEN:0]   o_fill;
    logic              o_afull;
    logic              o_aempty;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_wr, i_data, i_rd, i_clr_err,
        input  o_data, o_empty, o_full, o_fill, o_afull, o_aempty,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_wr, i_data, i_rd, i_clr_err,
        output o_data, o_empty, o_full, o_fill, o_afull, o_aempty,
               o_overflow, o_underflow
    );
endinterface

// File: rtl/sfifo_flags.sv
// Synchronous FIFO with threshold flags, sticky overflow/underflow and FWFT or registered read.
// Latency: flags 1 cycle after the accepting edge; FWFT data 0 cycles, registered data 1 cycle.
// Backpressure: writes while full and reads while empty are dropped and flagged as sticky errors.
module sfifo_flags #(
    parameter int BW         = 8,
    parameter int LGFLEN     = 4,
    parameter bit OPT_FWFT   = 1'b1,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    sfifo_flags_if.slave  bus
);
    localparam logic [LGFLEN:0] DEPTH = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [LGFLEN:0] AF    = (LGFLEN+1)'(AFULL_LVL);
    localparam logic [LGFLEN:0] AE    = (LGFLEN+1)'(AEMPTY_LVL);

    logic [BW-1:0]   mem [0:(1<<LGFLEN)-1];
    logic [LGFLEN:0] wr_addr, rd_addr, fill;
    logic            wr_acc, rd_acc;
    logic            overflow_q, underflow_q;

    assign fill            = wr_addr - rd_addr;
    assign bus.o_fill      = fill;
    assign bus.o_empty     = (fill == '0);
    assign bus.o_full      = (fill == DEPTH);
    assign bus.o_afull     = (fill >= AF);
    assign bus.o_aempty    = (fill <= AE);
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;

    assign wr_acc = i_reset_n && bus.i_wr && !bus.o_full;
    assign rd_acc = i_reset_n && bus.i_rd && !bus.o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            if (wr_acc) wr_addr <= wr_addr + 1'b1;
            if (rd_acc) rd_addr <= rd_addr + 1'b1;
        end
    end

    // A set event on the same edge takes priority over the clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.i_wr && bus.o_full)       overflow_q  <= 1'b1;
            else if (bus.i_clr_err)           overflow_q  <= 1'b0;
            if (bus.i_rd && bus.o_empty)      underflow_q <= 1'b1;
            else if (bus.i_clr_err)           underflow_q <= 1'b0;
        end
    end

    // Storage array is left unreset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wr_addr[LGFLEN-1:0]] <= bus.i_data;
    end

    generate
        if (OPT_FWFT) begin : g_fwft
            logic [LGFLEN:0] rd_next;
            logic [BW-1:0]   ram_q, byp_dat;
            logic            byp_vld;

            assign rd_next = rd_addr + {{LGFLEN{1'b0}}, rd_acc};

            // Prefetch the next head every cycle; when this edge writes the
            // slot that becomes head, the RAM still returns the old word, so
            // the write data is captured in the bypass register instead.
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    ram_q   <= '0;
                    byp_dat <= '0;
                    byp_vld <= 1'b0;
                end else begin
                    ram_q   <= mem[rd_next[LGFLEN-1:0]];
                    byp_dat <= bus.i_data;
                    byp_vld <= wr_acc && (wr_addr == rd_next);
                end
            end

            assign bus.o_data = byp_vld ? byp_dat : ram_q;
        end else begin : g_reg
            logic [BW-1:0] out_q;

            always_ff @(posedge i_clk) begin
                if (!i_reset_n)  out_q <= '0;
                else if (rd_acc) out_q <= mem[rd_addr[LGFLEN-1:0]];
            end

            assign bus.o_data = out_q;
        end
    endgenerate
endmodule
